// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: sequences a 4-function arithmetic unit (add/sub/mul/div).
// It takes one request at a time and holds the unit inputs stable for
// SETTLE_CYCLES cycles. It then captures the result and status flags, and
// presents them on a valid/ready response channel. Chaining takes operand A
// from the low nibble of the previous result.
module calc_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  // request channel
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [1:0] req_op,
  input  logic       req_chain,
  // arithmetic unit interface
  output logic [3:0] au_a,
  output logic [3:0] au_b,
  output logic [1:0] au_sel,
  input  logic [7:0] au_result,
  // response channel
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_result,
  output logic       resp_err,
  output logic       resp_ovf,
  // status
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Settle counter reload value; EXEC lasts SETTLE_CYCLES cycles (count S-1 down to 0).
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state_q,       state_d;
  logic [3:0] cnt_q,         cnt_d;
  logic [3:0] au_a_q,        au_a_d;
  logic [3:0] au_b_q,        au_b_d;
  logic [1:0] au_sel_q,      au_sel_d;
  logic [7:0] resp_result_q, resp_result_d;
  logic       resp_err_q,    resp_err_d;
  logic       resp_ovf_q,    resp_ovf_d;
  logic [7:0] op_count_q,    op_count_d;
  logic [3:0] last_lo_q,     last_lo_d;

  // Status flags derived from the held operands at 5-bit width.
  logic [4:0] sum5;
  logic [4:0] diff5;
  logic       div_by_zero;
  logic       ovf_now;

  // Flag computation from the registered unit inputs.
  always_comb begin
    sum5        = {1'b0, au_a_q} + {1'b0, au_b_q};
    diff5       = {1'b0, au_a_q} - {1'b0, au_b_q};
    div_by_zero = (au_sel_q == OP_DIV) && (au_b_q == 4'd0);
    ovf_now     = ((au_sel_q == OP_ADD) && sum5[4]) ||
                  ((au_sel_q == OP_SUB) && diff5[4]);
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    au_a_d        = au_a_q;
    au_b_d        = au_b_q;
    au_sel_d      = au_sel_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    resp_ovf_d    = resp_ovf_q;
    op_count_d    = op_count_q;
    last_lo_d     = last_lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          au_a_d   = req_chain ? last_lo_q : req_a;
          au_b_d   = req_b;
          au_sel_d = req_op;
          cnt_d    = SETTLE_LOAD;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          resp_result_d = div_by_zero ? 8'h00 : au_result;
          resp_err_d    = div_by_zero;
          resp_ovf_d    = ovf_now;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          op_count_d = op_count_q + 8'd1;
          last_lo_d  = resp_err_q ? 4'd0 : resp_result_q[3:0];
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      au_a_q        <= '0;
      au_b_q        <= '0;
      au_sel_q      <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      resp_ovf_q    <= 1'b0;
      op_count_q    <= '0;
      last_lo_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      au_a_q        <= au_a_d;
      au_b_q        <= au_b_d;
      au_sel_q      <= au_sel_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
      resp_ovf_q    <= resp_ovf_d;
      op_count_q    <= op_count_d;
      last_lo_q     <= last_lo_d;
    end
  end

  // Handshake and status outputs are decoded directly from the state register.
  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    resp_valid  = (state_q == ST_DONE);
    au_a        = au_a_q;
    au_b        = au_b_q;
    au_sel      = au_sel_q;
    resp_result = resp_result_q;
    resp_err    = resp_err_q;
    resp_ovf    = resp_ovf_q;
    op_count    = op_count_q;
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed testbench for calc_op_sequencer with a behavioural arithmetic unit.
module tb_calc_op_sequencer;

  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [1:0] req_op;
  logic       req_chain;
  logic [3:0] au_a;
  logic [3:0] au_b;
  logic [1:0] au_sel;
  logic [7:0] au_result;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_result;
  logic       resp_err;
  logic       resp_ovf;
  logic       busy;
  logic [7:0] op_count;

  int tests = 0;
  int fails = 0;
  int lat;
  int bcnt;

  calc_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .req_chain   (req_chain),
    .au_a        (au_a),
    .au_b        (au_b),
    .au_sel      (au_sel),
    .au_result   (au_result),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .resp_ovf    (resp_ovf),
    .busy        (busy),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  // Arithmetic unit model: add/sub in [3:0], mul full, div {q,r}; junk on /0.
  logic [3:0] au_sum4;
  logic [3:0] au_dif4;
  always_comb begin
    au_sum4 = au_a + au_b;
    au_dif4 = au_a - au_b;
    case (au_sel)
      2'b00:   au_result = {4'h0, au_sum4};
      2'b01:   au_result = {4'h0, au_dif4};
      2'b10:   au_result = {4'h0, au_a} * {4'h0, au_b};
      default: au_result = (au_b == 4'd0) ? 8'hFF : {au_a / au_b, au_a % au_b};
    endcase
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for resp_valid; lat counts edges from accept.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic ch, output int l, output int bc);
    req_a = a; req_b = b; req_op = op; req_chain = ch; req_valid = 1'b1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    step;
    req_valid = 1'b0; req_chain = 1'b0;
    l = 1; bc = 0;
    while (!resp_valid && l < 40) begin
      bc += int'(busy);
      step;
      l++;
    end
    bc += int'(busy);
    chk("resp_valid_timeout", {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic finish_op;
    resp_ready = 1'b1;
    step;
    resp_ready = 1'b0;
    chk("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    req_chain = 1'b0; resp_ready = 1'b0;
    step; step;
    rst = 1'b0;

    // Reset state
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_au", {22'd0, au_a, au_b, au_sel}, 32'd0);
    chk("rst_resp", {22'd0, resp_result, resp_err, resp_ovf}, 32'd0);
    chk("rst_op_count", {24'd0, op_count}, 32'd0);

    // Add with overflow: 9+8 -> 01, ovf
    do_op(4'd9, 4'd8, 2'b00, 1'b0, lat, bcnt);
    chk("add_latency", lat, 32'd3);
    chk("add_busy_cycles", bcnt, 32'd3);
    chk("add_result", {24'd0, resp_result}, 32'h01);
    chk("add_ovf", {31'd0, resp_ovf}, 32'd1);
    chk("add_err", {31'd0, resp_err}, 32'd0);
    chk("add_ready_busy", {30'd0, req_ready, busy}, 32'b01);
    finish_op;
    chk("add_op_count", {24'd0, op_count}, 32'd1);
    chk("add_idle_ready", {30'd0, req_ready, busy}, 32'b10);

    // Chained multiply / subtract
    do_op(4'd3, 4'd5, 2'b10, 1'b0, lat, bcnt);
    chk("mul1_result", {24'd0, resp_result}, 32'h0F);
    chk("mul1_ovf", {31'd0, resp_ovf}, 32'd0);
    finish_op;
    do_op(4'd0, 4'd2, 2'b10, 1'b1, lat, bcnt);
    chk("mul2_au_a", {28'd0, au_a}, 32'd15);
    chk("mul2_result", {24'd0, resp_result}, 32'h1E);
    finish_op;
    do_op(4'd0, 4'd15, 2'b01, 1'b1, lat, bcnt);
    chk("sub_au_a", {28'd0, au_a}, 32'd14);
    chk("sub_result", {24'd0, resp_result}, 32'h0F);
    chk("sub_ovf", {31'd0, resp_ovf}, 32'd1);
    finish_op;
    chk("chain_op_count", {24'd0, op_count}, 32'd4);

    // Divide, divide by zero, chain after error
    do_op(4'd13, 4'd4, 2'b11, 1'b0, lat, bcnt);
    chk("div_result", {24'd0, resp_result}, 32'h31);
    chk("div_err", {31'd0, resp_err}, 32'd0);
    finish_op;
    do_op(4'd7, 4'd0, 2'b11, 1'b0, lat, bcnt);
    chk("div0_result", {24'd0, resp_result}, 32'h00);
    chk("div0_err", {31'd0, resp_err}, 32'd1);
    chk("div0_ovf", {31'd0, resp_ovf}, 32'd0);
    finish_op;
    do_op(4'd9, 4'd3, 2'b00, 1'b1, lat, bcnt);
    chk("chain_err_au_a", {28'd0, au_a}, 32'd0);
    chk("chain_err_result", {24'd0, resp_result}, 32'h03);
    chk("chain_err_flags", {30'd0, resp_err, resp_ovf}, 32'd0);
    finish_op;
    step;
    chk("idle_retain_result", {24'd0, resp_result}, 32'h03);
    chk("idle_retain_au", {22'd0, au_a, au_b, au_sel}, {22'd0, 4'd0, 4'd3, 2'b00});

    // Backpressure with ignored requests
    do_op(4'd2, 4'd3, 2'b00, 1'b0, lat, bcnt);
    req_a = 4'd15; req_b = 4'd15; req_op = 2'b11; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_resp", {22'd0, resp_result, resp_err, resp_ovf}, {22'd0, 8'h05, 2'b00});
      chk("bp_au_hold", {22'd0, au_a, au_b, au_sel}, {22'd0, 4'd2, 4'd3, 2'b00});
      step;
    end
    req_valid = 1'b0;
    chk("bp_op_count_held", {24'd0, op_count}, 32'd7);
    finish_op;
    chk("bp_op_count", {24'd0, op_count}, 32'd8);
    step;
    chk("bp_no_capture", {22'd0, au_a, au_b, au_sel}, {22'd0, 4'd2, 4'd3, 2'b00});

    // Reset in second EXEC cycle
    req_a = 4'd4; req_b = 4'd4; req_op = 2'b00; req_valid = 1'b1;
    step;
    req_valid = 1'b0;
    step;
    chk("mid_exec_busy", {30'd0, busy, resp_valid}, 32'b10);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_state", {29'd0, req_ready, busy, resp_valid}, 32'b100);
    chk("mid_rst_au", {22'd0, au_a, au_b, au_sel}, 32'd0);
    chk("mid_rst_resp", {22'd0, resp_result, resp_err, resp_ovf}, 32'd0);
    chk("mid_rst_op_count", {24'd0, op_count}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step;
      chk("mid_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    // Chain right after reset uses A=0, then wrap op_count
    do_op(4'd11, 4'd5, 2'b00, 1'b1, lat, bcnt);
    chk("rst_chain_au_a", {28'd0, au_a}, 32'd0);
    chk("rst_chain_result", {24'd0, resp_result}, 32'h05);
    finish_op;
    for (int i = 1; i < 256; i++) begin
      do_op(4'(i), 4'd1, 2'b00, 1'b0, lat, bcnt);
      finish_op;
      if (i == 254) chk("wrap_255", {24'd0, op_count}, 32'd255);
    end
    chk("wrap_zero", {24'd0, op_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Controller that sequences the 4-function arithmetic unit (add/sub/mul/div on 4-bit operands, 8-bit result).
- Accepts one operation at a time over a valid/ready request channel and drives the unit's a/b/sel inputs from registers.
- Waits a fixed settle time, then captures the 8-bit result with status flags and returns it over a valid/ready response channel.
- Supports calculator-style chaining, where operand A is taken from the previous result's low nibble.

Parameters:
SETTLE_CYCLES, 2, number of cycles the unit inputs are held stable before result capture; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_a  input  4  operand A (ignored when req_chain=1)
req_b  input  4  operand B
req_op  input  2  00 add, 01 sub, 10 mul, 11 div
req_chain  input  1  use previous result low nibble as operand A
au_a  output  4  registered operand A to arithmetic unit
au_b  output  4  registered operand B to arithmetic unit
au_sel  output  2  registered op select to arithmetic unit
au_result  input  8  arithmetic unit result (add/sub in [3:0]; mul full 8 bits; div {quotient,remainder})
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_result  output  8  captured result
resp_err  output  1  divide by zero
resp_ovf  output  1  add carry-out or sub borrow
busy  output  1  high in EXEC or DONE
op_count  output  8  completed-transaction counter

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE.
  - au_a=0, au_b=0, au_sel=0.
  - resp_valid=0, resp_result=0, resp_err=0, resp_ovf=0.
  - op_count=0; chain register last_lo=0.
  - Reset has priority over every other event, including mid-EXEC or mid-DONE; any in-flight operation is discarded and no response is produced.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid=1: capture au_a = req_chain ? last_lo : req_a; au_b=req_b; au_sel=req_op; load settle counter with SETTLE_CYCLES-1; go to EXEC.
- EXEC:
  - req_ready=0, busy=1; au_* held stable.
  - Counter decrements each cycle.
  - In the cycle the counter is 0:
    - resp_result <= au_result, except for a divide by zero (see below).
    - resp_ovf <= (au_sel=00 and au_a+au_b>15) or (au_sel=01 and au_a<au_b); computed internally at 5-bit width.
    - resp_err <= (au_sel=11 and au_b=0).
    - Go to DONE.
- Divide by zero: resp_result forced to 8'h00 and resp_err=1; au_result is ignored.
- DONE:
  - resp_valid=1, busy=1, req_ready=0; resp_* stable while resp_valid=1 and resp_ready=0.
  - On resp_ready=1: resp_valid drops next cycle; op_count increments; go to IDLE.
  - last_lo <= resp_result[3:0], except on err, when last_lo <= 0.
- Latency:
  - Request accepted at edge N; resp_valid is first high in cycle N+SETTLE_CYCLES+1.
  - Minimum throughput is one operation per SETTLE_CYCLES+2 cycles (one IDLE cycle is mandatory between operations).
- req_valid while not in IDLE is ignored: req_ready=0, no capture.
- resp_ready while not in DONE is ignored.
- op_count wraps from 255 to 0 with no flag.
- Chaining immediately after reset uses A=0.
- resp_result/flags retain their last values in IDLE until the next capture; resp_valid alone qualifies them.
- au_* retain their last values in IDLE and DONE.

Test Plan:
- Add with overflow, SETTLE_CYCLES=2: req a=9 b=8 op=00 -> resp_valid at accept+3 cycles, result=8'h01, ovf=1, err=0; busy high for 3 cycles before response.
- Chained mul: req a=3 b=5 op=10 -> 8'h0F; then req_chain=1 b=2 op=10 -> au_a=15, result=8'h1E; then chain op=01 b=15 -> au_a=14, result=8'h0F, ovf=1.
- Divide: a=13 b=4 op=11 -> 8'h31, err=0. Then a=7 b=0 op=11 -> result=8'h00, err=1; a following chain uses A=0.
- Backpressure: hold resp_ready=0 for 10 cycles after resp_valid -> resp_* stable; req_valid pulses during this time are not accepted (req_ready=0); op_count increments exactly once on release.
- Reset mid-EXEC: assert rst in the second EXEC cycle -> next cycle IDLE, all outputs zero, no resp_valid ever for that request.
- Counter wrap: complete 256 ops -> op_count returns to 0.
